// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU producing a registered result, NZCV flags,
// a one-cycle done pulse and a status-write strobe (s_out) for the flag register.
// The flag register samples on negedge clk, so s_out comes from posedge registers.
// Optional feature macro ALU_MUL_EN: when defined, exe_cmd 1010 runs a
// DATA_WIDTH-iteration shift-add multiplier with a start/busy/done handshake.
// When undefined, 1010 is an unknown code and busy is tied low.
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            exe_cmd,
   input  logic [DATA_WIDTH-1:0] val1,
   input  logic [DATA_WIDTH-1:0] val2,
   input  logic                  s_in,
   input  logic                  c_in,
   input  logic                  v_in,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  n_out,
   output logic                  z_out,
   output logic                  c_out,
   output logic                  v_out,
   output logic                  s_out,
   output logic                  busy,
   output logic                  done
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
`ifdef ALU_MUL_EN
   localparam logic [3:0] CMD_MUL = 4'b1010;
`endif

   // Single-cycle evaluation; returns {N, Z, C, V, result}.
   // Subtraction is a + ~b + carry, so C=1 means "no borrow".
   function automatic logic [DATA_WIDTH+3:0] alu_eval(
      input logic [3:0]            cmd,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic                  ci,
      input logic                  vi
   );
      logic [DATA_WIDTH:0]   sum;
      logic [DATA_WIDTH-1:0] bx;
      logic [DATA_WIDTH-1:0] res;
      logic                  cin;
      logic                  arith;
      logic                  co;
      logic                  ov;
      sum   = '0;
      bx    = b;
      res   = '0;
      cin   = 1'b0;
      arith = 1'b0;
      co    = ci;
      ov    = vi;
      case (cmd)
         CMD_MOV: res = b;
         CMD_MVN: res = ~b;
         CMD_ADD: arith = 1'b1;
         CMD_ADC: begin arith = 1'b1; cin = ci; end
         CMD_SUB: begin arith = 1'b1; bx = ~b; cin = 1'b1; end
         CMD_SBC: begin arith = 1'b1; bx = ~b; cin = ci; end
         CMD_AND: res = a & b;
         CMD_ORR: res = a | b;
         CMD_EOR: res = a ^ b;
         default: res = '0;
      endcase
      if (arith) begin
         sum = {1'b0, a} + {1'b0, bx} + {{DATA_WIDTH{1'b0}}, cin};
         res = sum[DATA_WIDTH-1:0];
         co  = sum[DATA_WIDTH];
         ov  = (a[DATA_WIDTH-1] == bx[DATA_WIDTH-1]) && (res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      return {res[DATA_WIDTH-1], (res == '0), co, ov, res};
   endfunction

`ifdef ALU_MUL_EN
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [CNT_W-1:0]      count;
   logic                  s_cap;
   logic                  c_cap;
   logic                  v_cap;
   logic                  mul_go;

   assign mul_go = start && (exe_cmd == CMD_MUL);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM next state: MUL runs until the last iteration, then one DONE cycle
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (mul_go) state_next = MUL;
         MUL:     if (count == CNT_W'(1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shift-add multiplier: capture operands in IDLE, one iteration per MUL cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
         s_cap  <= 1'b0;
         c_cap  <= 1'b0;
         v_cap  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mul_go) begin
               acc    <= '0;
               mcand  <= val1;
               mplier <= val2;
               count  <= CNT_W'(DATA_WIDTH);
               s_cap  <= s_in;
               c_cap  <= c_in;
               v_cap  <= v_in;
            end
            MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // Registered outputs: single-cycle ops from IDLE, product from DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         n_out  <= 1'b0;
         z_out  <= 1'b0;
         c_out  <= 1'b0;
         v_out  <= 1'b0;
         s_out  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done  <= 1'b0;
         s_out <= 1'b0;
         busy  <= (state == MUL);
         case (state)
            IDLE: if (start && !mul_go) begin
               {n_out, z_out, c_out, v_out, result} <= alu_eval(exe_cmd, val1, val2, c_in, v_in);
               done  <= 1'b1;
               s_out <= s_in;
            end
            DONE: begin
               result <= acc;
               n_out  <= acc[DATA_WIDTH-1];
               z_out  <= (acc == '0);
               c_out  <= c_cap;
               v_out  <= v_cap;
               done   <= 1'b1;
               s_out  <= s_cap;
            end
            default: ;
         endcase
      end
   end
`else
   assign busy = 1'b0;

   // Registered outputs: every accepted start completes in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         n_out  <= 1'b0;
         z_out  <= 1'b0;
         c_out  <= 1'b0;
         v_out  <= 1'b0;
         s_out  <= 1'b0;
         done   <= 1'b0;
      end else begin
         done  <= 1'b0;
         s_out <= 1'b0;
         if (start) begin
            {n_out, z_out, c_out, v_out, result} <= alu_eval(exe_cmd, val1, val2, c_in, v_in);
            done  <= 1'b1;
            s_out <= s_in;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed bench for alu_exec_unit with a behavioural reference
// model (plain wide arithmetic, a cycle countdown for MUL) checked every cycle,
// plus hand-computed literal expectations. Follows the ALU_MUL_EN build choice.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  exe_cmd = 4'd0;
   logic [31:0] val1 = 32'd0;
   logic [31:0] val2 = 32'd0;
   logic        s_in = 1'b0;
   logic        c_in = 1'b0;
   logic        v_in = 1'b0;
   logic [31:0] result;
   logic        n_out, z_out, c_out, v_out, s_out, busy, done;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .exe_cmd(exe_cmd),
      .val1(val1), .val2(val2), .s_in(s_in), .c_in(c_in), .v_in(v_in),
      .result(result), .n_out(n_out), .z_out(z_out), .c_out(c_out),
      .v_out(v_out), .s_out(s_out), .busy(busy), .done(done)
   );

   // reference model state
   logic [31:0] m_result = 32'd0;
   logic        m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;
   logic        m_done = 1'b0, m_sout = 1'b0, m_busy = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_prod = 32'd0;
   logic        m_scap = 1'b0, m_ccap = 1'b0, m_vcap = 1'b0;

   // {N,Z,C,V,result} from exact unsigned and signed sums
   function automatic logic [35:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b, input logic ci, input logic vi);
      logic [63:0]        u;
      logic signed [63:0] s;
      logic [31:0]        bx;
      logic [31:0]        r;
      logic               cin, c, v, arith;
      u = 64'd0; s = 64'sd0; bx = b; r = 32'd0; cin = 1'b0; c = ci; v = vi; arith = 1'b0;
      case (cmd)
         4'b0001: r = b;
         4'b1001: r = ~b;
         4'b0010: arith = 1'b1;
         4'b0011: begin arith = 1'b1; cin = ci; end
         4'b0100: begin arith = 1'b1; bx = ~b; cin = 1'b1; end
         4'b0101: begin arith = 1'b1; bx = ~b; cin = ci; end
         4'b0110: r = a & b;
         4'b0111: r = a | b;
         4'b1000: r = a ^ b;
         default: r = 32'd0;
      endcase
      if (arith) begin
         u = {32'd0, a} + {32'd0, bx} + {63'd0, cin};
         s = $signed({{32{a[31]}}, a}) + $signed({{32{bx[31]}}, bx}) + $signed({63'd0, cin});
         r = u[31:0];
         c = (u >= 64'h1_0000_0000);
         v = (s != $signed({{32{r[31]}}, r}));
      end
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_result = 32'd0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
         m_done = 0; m_sout = 0; m_busy = 0; m_wait = 0;
      end else begin
         m_done = 0;
         m_sout = 0;
         if (m_wait > 0) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin
               m_result = m_prod; m_n = m_prod[31]; m_z = (m_prod == 32'd0);
               m_c = m_ccap; m_v = m_vcap; m_done = 1; m_sout = m_scap;
            end
         end else if (start) begin
`ifdef ALU_MUL_EN
            if (exe_cmd == 4'b1010) begin
               m_prod = val1 * val2;
               m_wait = 33;
               m_scap = s_in; m_ccap = c_in; m_vcap = v_in;
            end else
`endif
            begin
               {m_n, m_z, m_c, m_v, m_result} = ref_alu(exe_cmd, val1, val2, c_in, v_in);
               m_done = 1;
               m_sout = s_in;
            end
         end
         m_busy = (m_wait >= 1) && (m_wait <= 32);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_result", result, m_result);
         chk("cyc_nzcv", 32'({n_out, z_out, c_out, v_out}), 32'({m_n, m_z, m_c, m_v}));
         chk("cyc_done", 32'(done), 32'(m_done));
         chk("cyc_s_out", 32'(s_out), 32'(m_sout));
         chk("cyc_busy", 32'(busy), 32'(m_busy));
      end
   end

   task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic c, input logic v);
      @(negedge clk);
      exe_cmd = cmd; val1 = a; val2 = b; s_in = s; c_in = c; v_in = v; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [31:0] nzcv();
      return 32'({n_out, z_out, c_out, v_out});
   endfunction

   initial begin
      int ndone;
      int lat;
      logic [31:0] cap_res;
      logic [31:0] cap_flags;
      logic        cap_s;

      repeat (2) @(negedge clk);
      chk("reset_result", result, 32'h0);
      chk("reset_flags", nzcv(), 32'h0);
      chk("reset_busy_done", 32'({busy, done, s_out}), 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;

      op(4'b0010, 32'h7FFFFFFF, 32'h00000001, 1, 0, 0);
      chk("add_ovf_result", result, 32'h80000000);
      chk("add_ovf_nzcv", nzcv(), 32'h9);
      chk("add_ovf_done_s", 32'({done, s_out}), 32'h3);

      op(4'b0100, 32'd5, 32'd5, 1, 0, 0);
      chk("sub_eq_result", result, 32'h0);
      chk("sub_eq_nzcv", nzcv(), 32'h6);
      op(4'b0101, 32'd5, 32'd3, 1, 0, 0);
      chk("sbc_result", result, 32'h1);
      chk("sbc_nzcv", nzcv(), 32'h2);

`ifdef ALU_MUL_EN
      op(4'b1010, 32'h0000FFFF, 32'h00010001, 1, 1, 0);
      ndone = 0; lat = 0; cap_res = 0; cap_flags = 0; cap_s = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            start = 1'b1; exe_cmd = 4'b0010; val1 = 32'd1; val2 = 32'd1; s_in = 1'b0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            ndone++;
            if (lat == 0) begin
               lat = k; cap_res = result; cap_flags = nzcv(); cap_s = s_out;
            end
         end
      end
      start = 1'b0;
      chk("mul_latency", lat, 33);
      chk("mul_done_count", ndone, 1);
      chk("mul_result", cap_res, 32'hFFFFFFFF);
      chk("mul_nzcv", cap_flags, 32'hA);
      chk("mul_s_out", 32'(cap_s), 32'h1);
      chk("mul_hold", result, 32'hFFFFFFFF);

      op(4'b1010, 32'd3, 32'd4, 1, 0, 0);
      repeat (10) @(negedge clk);
`else
      op(4'b1010, 32'h0000FFFF, 32'h00010001, 1, 1, 0);
      chk("unk1010_result", result, 32'h0);
      chk("unk1010_nzcv", nzcv(), 32'h6);
      chk("unk1010_done_s", 32'({done, s_out, busy}), 32'h6);
      op(4'b0010, 32'd7, 32'd8, 1, 0, 0);
      chk("add78_result", result, 32'd15);
      repeat (3) @(negedge clk);
`endif
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_result", result, 32'h0);
      chk("rst_mid_ctrl", 32'({busy, done, s_out}), 32'h0);
      chk("rst_mid_flags", nzcv(), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("rst_no_done", ndone, 0);

      op(4'b0010, 32'd2, 32'd3, 1, 0, 0);
      chk("add23_result", result, 32'd5);

      op(4'b0110, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 1, 1);
      chk("and_result", result, 32'h0);
      chk("and_nzcv", nzcv(), 32'h7);
      chk("and_done_s", 32'({done, s_out}), 32'h2);

      op(4'b1001, 32'h0, 32'h0, 1, 0, 0);
      chk("mvn_result", result, 32'hFFFFFFFF);
      op(4'b0011, 32'hFFFFFFFF, 32'h0, 0, 1, 0);
      chk("adc_wrap_nzcv", nzcv(), 32'h6);
      op(4'b0100, 32'h80000000, 32'h1, 1, 0, 0);
      chk("sub_ovf_nzcv", nzcv(), 32'h3);
      op(4'b0100, 32'd3, 32'd5, 1, 1, 1);
      op(4'b0001, 32'h0, 32'h12345678, 0, 0, 1);
      op(4'b0111, 32'hA5000000, 32'h0000005A, 1, 1, 0);
      op(4'b1000, 32'hFFFF0000, 32'hFF00FF00, 1, 0, 0);
      op(4'b1111, 32'h1, 32'h2, 1, 0, 1);
      op(4'b0101, 32'h0, 32'h0, 1, 1, 0);
      repeat (3) @(negedge clk);
      chk("final_hold", result, 32'h0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
